// File: rtl/aemb_xsched_pkg.sv
// aemb_xsched_pkg: shared encodings and widths for the execution-stage sequencer
// Holds the instruction class codes, the FSM state encoding and the counter widths.
package aemb_xsched_pkg;
    localparam logic [2:0] CLS_ALU   = 3'd0;
    localparam logic [2:0] CLS_MUL   = 3'd1;
    localparam logic [2:0] CLS_BSF   = 3'd2;
    localparam logic [2:0] CLS_LOAD  = 3'd3;
    localparam logic [2:0] CLS_STORE = 3'd4;
    localparam logic [2:0] CLS_FSL   = 3'd5;
    localparam int CNT_W = 4;
    localparam int WDT_W = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MCYC = 2'd1,
        DBUS = 2'd2,
        FBUS = 2'd3
    } stateT;
endpackage

// File: rtl/aemb_xsched_wdt.sv
// aemb_xsched_wdt: bus watchdog counting strobe cycles and flagging expiry
// Ports: gclk/grst clock and async reset; en high while a bus strobe is out;
// expire high in the TMO-th consecutive strobe cycle.
module aemb_xsched_wdt
    import aemb_xsched_pkg::*;
#(
    parameter int TMO = 255
) (
    input  logic gclk,
    input  logic grst,
    input  logic en,
    output logic expire
);
    logic [WDT_W-1:0] count;
    always_ff @(posedge gclk or posedge grst)
        if (grst) count <= '0;
        else count <= en ? count + 1'b1 : '0;
    // count holds the strobe cycles already elapsed, so the TMO-th one sees TMO-1
    assign expire = en && (count == WDT_W'(TMO - 1));
endmodule

// File: rtl/aemb_xsched.sv
// aemb_xsched: execution-stage sequencer deciding pipeline advance and bus strobes
// Ports: gclk/grst clock and async reset; dec_vld/dec_cls/dec_skip decoded instruction;
// iwb_ack_i/dwb_ack_i/fsl_ack_i bus acknowledges; gena pipeline advance; xstall
// multi-cycle capture enable; dwb_stb_o/dwb_wre_o/fsl_stb_o registered bus strobes;
// xerr bus timeout pulse; busy state not IDLE.
// Build option AEMB_XSCHED_TMO_EN adds the bus watchdog; otherwise xerr stays 0.
module aemb_xsched
    import aemb_xsched_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int BSF_LAT = 1,
    parameter int TMO     = 255
) (
    input  logic       gclk,
    input  logic       grst,
    input  logic       dec_vld,
    input  logic [2:0] dec_cls,
    input  logic       dec_skip,
    input  logic       iwb_ack_i,
    input  logic       dwb_ack_i,
    input  logic       fsl_ack_i,
    output logic       gena,
    output logic       xstall,
    output logic       dwb_stb_o,
    output logic       dwb_wre_o,
    output logic       fsl_stb_o,
    output logic       xerr,
    output logic       busy
);
    stateT state;
    logic fin;
    logic [CNT_W-1:0] cnt;
    logic multi, launch, ack, expire;
    assign multi  = dec_vld && !dec_skip && dec_cls != CLS_ALU && dec_cls <= CLS_FSL;
    // fin blocks relaunching an instruction that already finished its long phase
    assign launch = state == IDLE && !fin && multi;
    assign gena   = !grst && state == IDLE && !launch && iwb_ack_i;
    assign xstall = state == MCYC;
    assign busy   = state != IDLE;
    assign ack    = (dwb_stb_o && dwb_ack_i) || (fsl_stb_o && fsl_ack_i);
`ifdef AEMB_XSCHED_TMO_EN
    aemb_xsched_wdt #(.TMO(TMO)) wdt (
        .gclk   (gclk),
        .grst   (grst),
        .en     (dwb_stb_o || fsl_stb_o),
        .expire (expire)
    );
`else
    // watchdog absent: never expires, TMO only referenced here
    assign expire = TMO < 0;
`endif
    always_ff @(posedge gclk or posedge grst)
        if (grst) begin
            state     <= IDLE;
            fin       <= 1'b0;
            cnt       <= '0;
            dwb_stb_o <= 1'b0;
            dwb_wre_o <= 1'b0;
            fsl_stb_o <= 1'b0;
            xerr      <= 1'b0;
        end else begin
            xerr <= 1'b0;
            case (state)
                IDLE:
                    if (launch) begin
                        if (dec_cls == CLS_MUL || dec_cls == CLS_BSF) begin
                            state <= MCYC;
                            cnt   <= dec_cls == CLS_MUL ? CNT_W'(MUL_LAT) : CNT_W'(BSF_LAT);
                        end else if (dec_cls == CLS_LOAD || dec_cls == CLS_STORE) begin
                            state     <= DBUS;
                            dwb_stb_o <= 1'b1;
                            dwb_wre_o <= dec_cls == CLS_STORE;
                        end else begin
                            state     <= FBUS;
                            fsl_stb_o <= 1'b1;
                        end
                    end else if (gena) fin <= 1'b0;
                MCYC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        fin   <= 1'b1;
                    end
                end
                default:
                    // an ack in the expiry cycle wins, so xerr only flags a true timeout
                    if (ack || expire) begin
                        state     <= IDLE;
                        fin       <= 1'b1;
                        dwb_stb_o <= 1'b0;
                        dwb_wre_o <= 1'b0;
                        fsl_stb_o <= 1'b0;
                        xerr      <= !ack;
                    end
            endcase
        end
endmodule
